sys_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter and transaction sequencer for the core's system bus (address, access type, write data, read data).
- Master 0 is the core's data-memory port; master 1 is the program loader/debug port.
- Captures one request at a time, drives it to the slave until the slave acknowledges, and returns read data with a one-cycle done pulse.
- Round-robin fairness; a watchdog aborts transactions the slave never acknowledges.

---
 rtl/sys_bus_arbiter.sv | 113 +++++++++++
 tb/tb_sys_bus_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bus_arbiter.sv
// Two-master, one-slave system bus arbiter with round-robin fairness,
// latched request forwarding and a watchdog that aborts unanswered accesses.
module sys_bus_arbiter #(
    parameter int unsigned      CPU_WIDTH = 32,
    parameter int unsigned      ACC_W     = 4,
    parameter logic [ACC_W-1:0] ACC_NONE  = '0,
    parameter int unsigned      TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CPU_WIDTH-1:0] m0_addr,
    input  logic [ACC_W-1:0]     m0_access_type,
    input  logic [CPU_WIDTH-1:0] m0_wdata,
    output logic [CPU_WIDTH-1:0] m0_rdata,
    output logic                 m0_done,
    input  logic [CPU_WIDTH-1:0] m1_addr,
    input  logic [ACC_W-1:0]     m1_access_type,
    input  logic [CPU_WIDTH-1:0] m1_wdata,
    output logic [CPU_WIDTH-1:0] m1_rdata,
    output logic                 m1_done,
    output logic [CPU_WIDTH-1:0] s_addr,
    output logic [ACC_W-1:0]     s_access_type,
    output logic [CPU_WIDTH-1:0] s_wdata,
    input  logic [CPU_WIDTH-1:0] s_rdata,
    input  logic                 s_ready,
    output logic [1:0]           grant,
    output logic                 timeout_err
);

    localparam int unsigned     WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY0,
        BUSY1
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wd;
    logic            last_m1;
    logic            req0;
    logic            req1;
    logic            pick1;

    // A master in its done cycle is still holding the old request; it only
    // counts as a new request from the following cycle on.
    assign req0  = (m0_access_type != ACC_NONE) && !m0_done;
    assign req1  = (m1_access_type != ACC_NONE) && !m1_done;
    assign pick1 = req1 && (!req0 || !last_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grant         <= '0;
            s_addr        <= '0;
            s_access_type <= ACC_NONE;
            s_wdata       <= '0;
            m0_rdata      <= '0;
            m1_rdata      <= '0;
            m0_done       <= 1'b0;
            m1_done       <= 1'b0;
            timeout_err   <= 1'b0;
            last_m1       <= 1'b1;
            wd            <= '0;
        end else begin
            m0_done     <= 1'b0;
            m1_done     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        wd      <= '0;
                        last_m1 <= pick1;
                        if (pick1) begin
                            state         <= BUSY1;
                            grant         <= 2'b10;
                            s_addr        <= m1_addr;
                            s_access_type <= m1_access_type;
                            s_wdata       <= m1_wdata;
                        end else begin
                            state         <= BUSY0;
                            grant         <= 2'b01;
                            s_addr        <= m0_addr;
                            s_access_type <= m0_access_type;
                            s_wdata       <= m0_wdata;
                        end
                    end
                end
                BUSY0, BUSY1: begin
                    // s_ready wins over the watchdog on the final wait cycle.
                    if (s_ready || wd == WD_LAST) begin
                        state         <= IDLE;
                        grant         <= '0;
                        s_access_type <= ACC_NONE;
                        timeout_err   <= !s_ready;
                        if (state == BUSY1) begin
                            m1_done  <= 1'b1;
                            m1_rdata <= s_ready ? s_rdata : '0;
                        end else begin
                            m0_done  <= 1'b1;
                            m0_rdata <= s_ready ? s_rdata : '0;
                        end
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Bench for sys_bus_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_sys_bus_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic [3:0]  m0_access_type = '0, m1_access_type = '0;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [31:0] s_rdata = '0;
    logic [3:0]  s_access_type;
    logic        m0_done, m1_done, s_ready = 1'b0, timeout_err;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;

    sys_bus_arbiter #(
        .CPU_WIDTH(32),
        .ACC_W    (4),
        .ACC_NONE (4'd0),
        .TIMEOUT  (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m0_addr       (m0_addr),
        .m0_access_type(m0_access_type),
        .m0_wdata      (m0_wdata),
        .m0_rdata      (m0_rdata),
        .m0_done       (m0_done),
        .m1_addr       (m1_addr),
        .m1_access_type(m1_access_type),
        .m1_wdata      (m1_wdata),
        .m1_rdata      (m1_rdata),
        .m1_done       (m1_done),
        .s_addr        (s_addr),
        .s_access_type (s_access_type),
        .s_wdata       (s_wdata),
        .s_rdata       (s_rdata),
        .s_ready       (s_ready),
        .grant         (grant),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_master(input int m, input logic [3:0] t, input logic [31:0] a, input logic [31:0] d);
        if (m == 0) begin
            m0_access_type = t; m0_addr = a; m0_wdata = d;
        end else begin
            m1_access_type = t; m1_addr = a; m1_wdata = d;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({grant, s_access_type, s_addr, s_wdata, m0_rdata, m1_rdata, m0_done, m1_done, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got grant=%b acc=%h addr=%h wd=%h r0=%h r1=%h d=%b%b te=%b exp all zero",
                     grant, s_access_type, s_addr, s_wdata, m0_rdata, m1_rdata, m0_done, m1_done, timeout_err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        drive_master(0, 4'h2, 32'h0000_0010, 32'h0);
        tick();
        checks++;
        if ({grant, s_access_type, s_addr} !== {2'b01, 4'h2, 32'h10}) begin
            errors++;
            $display("FAIL read_issue got grant=%b acc=%h addr=%h exp 01 2 00000010", grant, s_access_type, s_addr);
        end
        tick();
        checks++;
        if ({grant, m0_done} !== {2'b01, 1'b0}) begin
            errors++;
            $display("FAIL read_wait got grant=%b done=%b exp 01 0", grant, m0_done);
        end
        s_ready = 1'b1;
        s_rdata = 32'hDEAD_BEEF;
        tick();
        s_ready = 1'b0;
        checks++;
        if ({m0_done, m0_rdata, grant, s_access_type} !== {1'b1, 32'hDEAD_BEEF, 2'b00, 4'h0}) begin
            errors++;
            $display("FAIL read_done got done=%b rdata=%h grant=%b acc=%h exp 1 deadbeef 00 0",
                     m0_done, m0_rdata, grant, s_access_type);
        end
        m0_access_type = 4'h0;
        tick();
        checks++;
        if ({m0_done, m0_rdata, grant} !== {1'b0, 32'hDEAD_BEEF, 2'b00}) begin
            errors++;
            $display("FAIL read_after got done=%b rdata=%h grant=%b exp 0 deadbeef 00", m0_done, m0_rdata, grant);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] eg;
        logic [1:0] ed;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive_master(0, 4'h2, 32'h200, 32'h0);
        drive_master(1, 4'h2, 32'h300, 32'h0);
        s_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            eg = (c % 2 == 0) ? 2'b00 : ((((c - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10);
            ed = (c % 4 == 2) ? 2'b01 : ((c % 4 == 0) ? 2'b10 : 2'b00);
            checks++;
            if ({grant, m1_done, m0_done} !== {eg, ed}) begin
                errors++;
                $display("FAIL rr_cycle%0d got grant=%b done=%b%b exp %b %b", c, grant, m1_done, m0_done, eg, ed);
            end
            if (c % 4 == 2) begin
                checks++;
                if (m0_rdata !== 32'hCAFE_0000 + 32'(c - 1)) begin
                    errors++;
                    $display("FAIL rr_rdata%0d got %h exp %h", c, m0_rdata, 32'hCAFE_0000 + 32'(c - 1));
                end
            end
            s_rdata = 32'hCAFE_0000 + 32'(c);
            if (c == 8) begin
                m0_access_type = 4'h0;
                m1_access_type = 4'h0;
                s_ready = 1'b0;
            end
        end
        tick();
        checks++;
        if (grant !== 2'b00) begin
            errors++;
            $display("FAIL rr_idle got grant=%b exp 00", grant);
        end
    endtask

    task automatic test_write_stability();
        drive_master(1, 4'h8, 32'h100, 32'h1234_5678);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if ({grant, s_addr, s_wdata, s_access_type, m1_done} !== {2'b10, 32'h100, 32'h1234_5678, 4'h8, 1'b0}) begin
                errors++;
                $display("FAIL wr_stable%0d got grant=%b addr=%h wdata=%h acc=%h done=%b exp 10 100 12345678 8 0",
                         k, grant, s_addr, s_wdata, s_access_type, m1_done);
            end
            if (k == 1) drive_master(1, 4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            if (k == 6) begin
                s_ready = 1'b1;
                s_rdata = 32'h0BAD_F00D;
            end
        end
        tick();
        s_ready = 1'b0;
        checks++;
        if ({m1_done, m1_rdata, grant} !== {1'b1, 32'h0BAD_F00D, 2'b00}) begin
            errors++;
            $display("FAIL wr_done got done=%b rdata=%h grant=%b exp 1 0badf00d 00", m1_done, m1_rdata, grant);
        end
        m1_access_type = 4'h0;
        tick();
    endtask

    task automatic test_timeout();
        drive_master(0, 4'h2, 32'h40, 32'h0);
        for (int k = 1; k <= TMO; k++) begin
            tick();
            checks++;
            if ({grant, m0_done, timeout_err} !== {2'b01, 2'b00}) begin
                errors++;
                $display("FAIL to_wait%0d got grant=%b done=%b terr=%b exp 01 0 0", k, grant, m0_done, timeout_err);
            end
            if (k == 1) drive_master(1, 4'h2, 32'h80, 32'h0);
        end
        tick();
        checks++;
        if ({m0_done, m0_rdata, timeout_err, grant} !== {1'b1, 32'h0, 1'b1, 2'b00}) begin
            errors++;
            $display("FAIL to_abort got done=%b rdata=%h terr=%b grant=%b exp 1 0 1 00",
                     m0_done, m0_rdata, timeout_err, grant);
        end
        m0_access_type = 4'h0;
        tick();
        checks++;
        if ({grant, s_addr, m0_done, timeout_err} !== {2'b10, 32'h80, 2'b00}) begin
            errors++;
            $display("FAIL to_next got grant=%b addr=%h done=%b terr=%b exp 10 80 0 0",
                     grant, s_addr, m0_done, timeout_err);
        end
        s_ready = 1'b1;
        s_rdata = 32'h1;
        tick();
        s_ready = 1'b0;
        m1_access_type = 4'h0;
        checks++;
        if ({m1_done, m1_rdata} !== {1'b1, 32'h1}) begin
            errors++;
            $display("FAIL to_m1done got done=%b rdata=%h exp 1 1", m1_done, m1_rdata);
        end
        tick();
    endtask

    task automatic test_ready_on_abort();
        drive_master(0, 4'h2, 32'h44, 32'h0);
        for (int k = 1; k <= TMO; k++) begin
            tick();
            if (k == TMO) begin
                s_ready = 1'b1;
                s_rdata = 32'hA5A5_A5A5;
            end
        end
        tick();
        s_ready = 1'b0;
        checks++;
        if ({m0_done, m0_rdata, timeout_err} !== {1'b1, 32'hA5A5_A5A5, 1'b0}) begin
            errors++;
            $display("FAIL abort_race got done=%b rdata=%h terr=%b exp 1 a5a5a5a5 0", m0_done, m0_rdata, timeout_err);
        end
        m0_access_type = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid_op();
        drive_master(1, 4'h2, 32'h500, 32'h0);
        tick();
        checks++;
        if (grant !== 2'b10) begin
            errors++;
            $display("FAIL rmo_grant got %b exp 10", grant);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({grant, s_access_type, m1_done} !== {2'b00, 4'h0, 1'b0}) begin
            errors++;
            $display("FAIL rmo_reset got grant=%b acc=%h done=%b exp 00 0 0", grant, s_access_type, m1_done);
        end
        rst = 1'b0;
        drive_master(0, 4'h2, 32'h600, 32'h0);
        tick();
        checks++;
        if ({grant, m1_done} !== {2'b01, 1'b0}) begin
            errors++;
            $display("FAIL rmo_after got grant=%b done1=%b exp 01 0", grant, m1_done);
        end
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        m0_access_type = 4'h0;
        m1_access_type = 4'h0;
        checks++;
        if ({m0_done, m1_done} !== 2'b10) begin
            errors++;
            $display("FAIL rmo_done got d0=%b d1=%b exp 1 0", m0_done, m1_done);
        end
        tick();
    endtask

    // Reference model: tracks which master owns the bus and how many cycles
    // the current access has been outstanding; outputs follow one cycle later.
    task automatic test_random();
        int          own, busy, last, dly, w;
        bit          md[2], pd[2], act[2];
        bit          mt, r0, r1, newt;
        logic [31:0] mr[2];
        logic [31:0] la, lw;
        logic [3:0]  lt;
        logic [1:0]  eg;
        rst = 1'b1;
        m0_access_type = 4'h0;
        m1_access_type = 4'h0;
        s_ready = 1'b0;
        tick();
        rst = 1'b0;
        own = -1; busy = 0; last = 1; dly = 0; mt = 1'b0;
        md = '{0, 0}; act = '{0, 0}; mr = '{32'h0, 32'h0};
        la = '0; lw = '0; lt = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk);
            pd = md;
            md = '{0, 0};
            mt = 1'b0;
            if (own >= 0) begin
                if (s_ready) begin
                    md[own] = 1'b1; mr[own] = s_rdata; own = -1;
                end else if (busy == TMO) begin
                    md[own] = 1'b1; mr[own] = '0; mt = 1'b1; own = -1;
                end else begin
                    busy++;
                end
            end else begin
                r0 = (m0_access_type != 4'h0) && !pd[0];
                r1 = (m1_access_type != 4'h0) && !pd[1];
                w = (r0 && r1) ? ((last == 0) ? 1 : 0) : (r0 ? 0 : (r1 ? 1 : -1));
                if (w >= 0) begin
                    own = w; busy = 1; last = w;
                    la = (w == 0) ? m0_addr : m1_addr;
                    lw = (w == 0) ? m0_wdata : m1_wdata;
                    lt = (w == 0) ? m0_access_type : m1_access_type;
                end
            end
            #1;
            eg = (own == 0) ? 2'b01 : ((own == 1) ? 2'b10 : 2'b00);
            checks++;
            if ({grant, s_access_type} !== {eg, (own >= 0) ? lt : 4'h0}) begin
                errors++;
                $display("FAIL rnd_bus@%0d got grant=%b acc=%h exp %b %h", cyc, grant, s_access_type, eg,
                         (own >= 0) ? lt : 4'h0);
            end
            if (own >= 0) begin
                checks++;
                if ({s_addr, s_wdata} !== {la, lw}) begin
                    errors++;
                    $display("FAIL rnd_payload@%0d got addr=%h wdata=%h exp %h %h", cyc, s_addr, s_wdata, la, lw);
                end
            end
            checks++;
            if ({m0_done, m1_done, timeout_err, m0_rdata, m1_rdata} !== {md[0], md[1], mt, mr[0], mr[1]}) begin
                errors++;
                $display("FAIL rnd_resp@%0d got d=%b%b te=%b r0=%h r1=%h exp d=%b%b te=%b r0=%h r1=%h", cyc,
                         m0_done, m1_done, timeout_err, m0_rdata, m1_rdata, md[0], md[1], mt, mr[0], mr[1]);
            end
            for (int m = 0; m < 2; m++) begin
                newt = 1'b0;
                if (md[m]) begin
                    act[m] = 1'($urandom_range(0, 1));
                    newt = act[m];
                end else if (!act[m] && $urandom_range(0, 2) == 0) begin
                    act[m] = 1'b1;
                    newt = 1'b1;
                end else if (act[m] && own != m && $urandom_range(0, 15) == 0) begin
                    act[m] = 1'b0;
                end
                if (newt)
                    drive_master(m, 4'($urandom_range(1, 15)), $urandom, $urandom);
                else if (act[m] && own == m)
                    drive_master(m, (m == 0) ? m0_access_type : m1_access_type, $urandom, $urandom);
                else if (!act[m])
                    drive_master(m, 4'h0, $urandom, $urandom);
            end
            if (own >= 0) begin
                if (busy == 1)
                    dly = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(TMO - 2, TMO + 1));
                s_ready = (busy == dly + 1);
            end else begin
                s_ready = 1'($urandom_range(0, 1));
            end
            s_rdata = $urandom;
        end
        m0_access_type = 4'h0;
        m1_access_type = 4'h0;
        s_ready = 1'b0;
        repeat (TMO + 3) tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_stability();
        test_timeout();
        test_ready_on_abort();
        test_reset_mid_op();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
